// File: rtl/pwm_if.sv
// Signal bundle between the PWM feedback line and its decoder.
// The master drives the line; the slave (decoder) returns the measurements.
interface pwm_if #(
  parameter int unsigned CNT_W = 28
);
  logic             pwm_in;
  logic [1:0]       giro_det;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic             meas_valid;
  logic             locked;
  logic             stuck;

  modport master (
    output pwm_in,
    input  giro_det, high_cnt, period_cnt, meas_valid, locked, stuck
  );

  modport slave (
    input  pwm_in,
    output giro_det, high_cnt, period_cnt, meas_valid, locked, stuck
  );
endinterface

// File: rtl/pwm_decoder.sv
// Measures period and high time of the motor PWM feedback line, classifies the duty
// into a 2-bit speed level and flags a dead or stuck line.
module pwm_decoder #(
  parameter int unsigned CNT_W   = 28,
  parameter int unsigned TH1     = 2_000_000,
  parameter int unsigned TH2     = 5_500_000,
  parameter int unsigned TH3     = 8_400_000,
  parameter int unsigned TIMEOUT = 20_000_000
) (
  input logic   clk,
  input logic   reset,
  pwm_if.slave  bus
);

  typedef enum logic [1:0] {StWaitEdge, StMeasure, StStuck} state_e;

  localparam logic [CNT_W-1:0] Th1     = CNT_W'(TH1);
  localparam logic [CNT_W-1:0] Th2     = CNT_W'(TH2);
  localparam logic [CNT_W-1:0] Th3     = CNT_W'(TH3);
  localparam logic [CNT_W-1:0] Timeout = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  state_e           state_q, state_d;
  logic             s1_q, s2_q, prev_q;
  logic             rise;
  logic [CNT_W-1:0] idle_q, idle_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [1:0]       giro_q, giro_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             stuck_q, stuck_d;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic b);
    return (a == CntMax) ? a : a + CNT_W'(b);
  endfunction

  function automatic logic [1:0] classify(input logic [CNT_W-1:0] h);
    if (h < Th1)      return 2'd0;
    else if (h < Th2) return 2'd1;
    else if (h < Th3) return 2'd2;
    else              return 2'd3;
  endfunction

  assign rise = s2_q & ~prev_q;

  always_comb begin
    state_d  = state_q;
    idle_d   = idle_q;
    per_d    = per_q;
    hi_d     = hi_q;
    period_d = period_q;
    high_d   = high_q;
    giro_d   = giro_q;
    valid_d  = 1'b0;
    locked_d = locked_q;
    stuck_d  = stuck_q;
    unique case (state_q)
      StWaitEdge: begin
        idle_d = sat_add(idle_q, 1'b1);
        if (rise) begin
          state_d = StMeasure;
          per_d   = CntOne;
          hi_d    = CntOne;
          idle_d  = '0;
        end else if (idle_q == Timeout) begin
          state_d  = StStuck;
          stuck_d  = 1'b1;
          locked_d = 1'b0;
          giro_d   = {2{s2_q}};
        end
      end
      StMeasure: begin
        per_d = sat_add(per_q, 1'b1);
        hi_d  = sat_add(hi_q, s2_q);
        // A rise coinciding with the timeout is a valid period, not a dead line.
        if (rise) begin
          period_d = per_q;
          high_d   = hi_q;
          giro_d   = classify(hi_q);
          valid_d  = 1'b1;
          locked_d = 1'b1;
          per_d    = CntOne;
          hi_d     = CntOne;
        end else if (per_q == Timeout) begin
          state_d  = StStuck;
          stuck_d  = 1'b1;
          locked_d = 1'b0;
          giro_d   = {2{s2_q}};
        end
      end
      StStuck: begin
        giro_d = {2{s2_q}};
        if (rise) begin
          state_d = StMeasure;
          per_d   = CntOne;
          hi_d    = CntOne;
          stuck_d = 1'b0;
        end
      end
      default: state_d = StWaitEdge;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StWaitEdge;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      prev_q   <= 1'b0;
      idle_q   <= '0;
      per_q    <= '0;
      hi_q     <= '0;
      period_q <= '0;
      high_q   <= '0;
      giro_q   <= 2'd0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      stuck_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      s1_q     <= bus.pwm_in;
      s2_q     <= s1_q;
      prev_q   <= s2_q;
      idle_q   <= idle_d;
      per_q    <= per_d;
      hi_q     <= hi_d;
      period_q <= period_d;
      high_q   <= high_d;
      giro_q   <= giro_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      stuck_q  <= stuck_d;
    end
  end

  assign bus.giro_det   = giro_q;
  assign bus.high_cnt   = high_q;
  assign bus.period_cnt = period_q;
  assign bus.meas_valid = valid_q;
  assign bus.locked     = locked_q;
  assign bus.stuck      = stuck_q;

endmodule

// File: tb/tb_pwm_decoder.sv
// Bench for pwm_decoder: per-cycle comparison against a timestamp-based reference model,
// a duty/level table, hand-written reset/stuck/timeout sequences and random waveforms.
module tb_pwm_decoder;

  localparam int unsigned CW   = 8;
  localparam int unsigned T1   = 4;
  localparam int unsigned T2   = 10;
  localparam int unsigned T3   = 16;
  localparam int unsigned TO   = 50;
  localparam int          MAXC = 8192;

  logic clk = 1'b0;
  logic reset = 1'b1;

  pwm_if #(.CNT_W(CW)) bus ();

  pwm_decoder #(
    .CNT_W   (CW),
    .TH1     (T1),
    .TH2     (T2),
    .TH3     (T3),
    .TIMEOUT (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int p;
    int h;
    int exp_per;
    int exp_high;
    int exp_giro;
  } vec_t;

  int total = 0;
  int bad = 0;
  int k = 0;
  bit w_h[MAXC];
  bit r_h[MAXC];

  // Reference model state: time of last seen rise, stuck flag, last reset time.
  int last_rise = -1;
  bit m_stuck = 1'b0;
  int rst_time = 0;
  int e_giro = 0, e_high = 0, e_per = 0;
  bit e_valid = 0, e_locked = 0, e_stuck = 0;

  int cap_per = 0, cap_high = 0, cap_giro = 0;
  int pulses = 0;

  // Line level as seen by the decoder at edge n: input two edges back, blanked by reset.
  function automatic bit seen(int n);
    if (n < 2) return 1'b0;
    return !(r_h[n-1] || r_h[n-2]) && w_h[n-2];
  endfunction

  function automatic bit seen_prev(int n);
    if (n < 1) return 1'b0;
    return !r_h[n-1] && seen(n-1);
  endfunction

  function automatic int cls(int h);
    if (h < int'(T1)) return 0;
    if (h < int'(T2)) return 1;
    if (h < int'(T3)) return 2;
    return 3;
  endfunction

  task automatic model_edge(int n);
    bit rise;
    int hs;
    e_valid = 1'b0;
    if (r_h[n]) begin
      e_giro = 0; e_high = 0; e_per = 0; e_locked = 0; e_stuck = 0;
      last_rise = -1; m_stuck = 1'b0; rst_time = n;
      return;
    end
    rise = seen(n) && !seen_prev(n);
    if (rise) begin
      if (m_stuck) begin
        m_stuck = 1'b0; e_stuck = 0; e_giro = 3;
      end else if (last_rise >= 0) begin
        hs = 0;
        for (int j = last_rise; j < n; j++) hs += int'(seen(j));
        e_per = n - last_rise; e_high = hs; e_giro = cls(hs);
        e_valid = 1'b1; e_locked = 1'b1;
      end
      last_rise = n;
    end else if (m_stuck) begin
      e_giro = seen(n) ? 3 : 0;
    end else if ((last_rise >= 0 && n - last_rise == int'(TO)) ||
                 (last_rise < 0 && n - rst_time - 1 == int'(TO))) begin
      m_stuck = 1'b1; e_stuck = 1; e_locked = 0;
      e_giro = seen(n) ? 3 : 0;
    end
  endtask

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, k);
    end
  endtask

  task automatic cyc(bit r, bit p);
    logic [20:0] act, exp;
    if (k >= MAXC) begin
      $display("FAIL cycle_budget: got %0d cycles, expected below %0d", k, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    @(negedge clk);
    reset = r;
    bus.pwm_in = p;
    w_h[k] = p;
    r_h[k] = r;
    @(posedge clk);
    model_edge(k);
    #1;
    act = {bus.giro_det, bus.high_cnt, bus.period_cnt, bus.meas_valid, bus.locked, bus.stuck};
    exp = {e_giro[1:0], e_high[7:0], e_per[7:0], e_valid, e_locked, e_stuck};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL cycle: edge %0d got giro=%0d high=%0d per=%0d v=%0b l=%0b s=%0b, expected %h",
               k, bus.giro_det, bus.high_cnt, bus.period_cnt, bus.meas_valid, bus.locked,
               bus.stuck, exp);
    end
    if (bus.meas_valid === 1'b1) begin
      cap_per = int'(bus.period_cnt);
      cap_high = int'(bus.high_cnt);
      cap_giro = int'(bus.giro_det);
      pulses++;
    end
    k++;
  endtask

  task automatic run_period(int p, int h);
    for (int i = 0; i < p; i++) cyc(1'b0, i < h);
  endtask

  task automatic check_zero(string name);
    check(name, int'({bus.giro_det, bus.high_cnt, bus.period_cnt, bus.meas_valid,
                      bus.locked, bus.stuck}), 0);
  endtask

  vec_t tbl[12];

  initial begin
    bus.pwm_in = 1'b0;
    tbl[0]  = '{20, 5, 20, 5, 1};
    tbl[1]  = '{20, 1, 20, 1, 0};
    tbl[2]  = '{20, 8, 20, 8, 1};
    tbl[3]  = '{20, 12, 20, 12, 2};
    tbl[4]  = '{20, 19, 20, 19, 3};
    tbl[5]  = '{20, 3, 20, 3, 0};
    tbl[6]  = '{20, 4, 20, 4, 1};
    tbl[7]  = '{20, 9, 20, 9, 1};
    tbl[8]  = '{20, 10, 20, 10, 2};
    tbl[9]  = '{20, 15, 20, 15, 2};
    tbl[10] = '{20, 16, 20, 16, 3};
    tbl[11] = '{7, 3, 7, 3, 0};

    // Reset held with the line toggling.
    for (int i = 0; i < 5; i++) cyc(1'b1, i[0]);
    check_zero("reset_outputs");

    // First rise after reset must not produce a measurement.
    pulses = 0;
    run_period(20, 5);
    check("first_period_pulses", pulses, 0);
    run_period(20, 5);
    run_period(20, 5);
    check("locked_after_first_meas", int'(bus.locked), 1);
    check("steady_period", cap_per, 20);
    check("steady_high", cap_high, 5);

    // Reset mid-period discards the partial measurement.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    check_zero("mid_reset_outputs");
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0);
    pulses = 0;
    run_period(20, 5);
    check("post_reset_first_pulses", pulses, 0);
    run_period(20, 5);
    run_period(20, 5);
    check("post_reset_pulses", pulses, 2);

    // Duty table.
    foreach (tbl[i]) begin
      for (int r = 0; r < 3; r++) run_period(tbl[i].p, tbl[i].h);
      check($sformatf("tbl%0d_period", i), cap_per, tbl[i].exp_per);
      check($sformatf("tbl%0d_high", i), cap_high, tbl[i].exp_high);
      check($sformatf("tbl%0d_giro", i), cap_giro, tbl[i].exp_giro);
    end

    // Stuck low, then stuck high; measurements must hold.
    for (int r = 0; r < 3; r++) run_period(20, 5);
    for (int i = 0; i < 60; i++) cyc(1'b0, 1'b0);
    check("stuck_low_flag", int'(bus.stuck), 1);
    check("stuck_low_locked", int'(bus.locked), 0);
    check("stuck_low_giro", int'(bus.giro_det), 0);
    check("stuck_low_period_hold", int'(bus.period_cnt), 20);
    check("stuck_low_high_hold", int'(bus.high_cnt), 5);
    for (int i = 0; i < 60; i++) cyc(1'b0, 1'b1);
    check("stuck_high_flag", int'(bus.stuck), 1);
    check("stuck_high_giro", int'(bus.giro_det), 3);
    check("stuck_high_period_hold", int'(bus.period_cnt), 20);
    check("stuck_high_high_hold", int'(bus.high_cnt), 5);

    // Recovery from stuck.
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0);
    pulses = 0;
    run_period(20, 12);
    check("recover_stuck_cleared", int'(bus.stuck), 0);
    check("recover_no_pulse_yet", pulses, 0);
    run_period(20, 12);
    run_period(20, 12);
    check("recover_period", cap_per, 20);
    check("recover_high", cap_high, 12);
    check("recover_giro", cap_giro, 2);
    check("recover_locked", int'(bus.locked), 1);

    // Rise exactly at the timeout count.
    for (int r = 0; r < 3; r++) run_period(50, 10);
    check("timeout_edge_period", cap_per, 50);
    check("timeout_edge_high", cap_high, 10);
    check("timeout_edge_stuck", int'(bus.stuck), 0);

    // Random waveforms, including periods beyond the timeout.
    for (int n = 0; n < 40; n++) begin
      int p, h;
      p = int'($urandom_range(2, 60));
      h = int'($urandom_range(1, p - 1));
      for (int r = 0; r < 1 + int'($urandom_range(0, 2)); r++) run_period(p, h);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
